// File: rtl/piece_pkg.sv
// Shared types and defaults for the 7-bag piece generator.
package piece_pkg;

    localparam int PIECE_ID_W   = 3;
    localparam int PIECE_COUNT  = 7;
    localparam int DEFAULT_LFSR_W = 16;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [PIECE_ID_W-1:0] {
        P_I = 3'd0,
        P_O = 3'd1,
        P_T = 3'd2,
        P_S = 3'd3,
        P_Z = 3'd4,
        P_J = 3'd5,
        P_L = 3'd6
    } piece_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_PUSH
    } state_t;

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with reseed; an all-zero seed is replaced so it never locks up.
module lfsr_core #(
    parameter int W = 16,
    parameter logic [W-1:0] TAPS = 16'hB400,
    parameter logic [W-1:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] SAFE_SEED = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] shifted;

    assign shifted = {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= SAFE_SEED;
        end else if (load) begin
            q <= (load_val == '0) ? SAFE_SEED : load_val;
        end else begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/piece_bag_gen.sv
// 7-bag piece dealer feeding a head + preview FIFO from an LFSR.
// Optional `define PIECE_PURE_RAND_EN adds a pure_rand input that bypasses the bag rule.
module piece_bag_gen
    import piece_pkg::*;
#(
    parameter int LFSR_W        = DEFAULT_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS,
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter int NUM_PIECES    = PIECE_COUNT,
    parameter int ID_W          = PIECE_ID_W,
    parameter int PREVIEW_DEPTH = 3,
    parameter int MAX_TRIES     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          block_new,
    input  logic                          seed_load,
    input  logic [LFSR_W-1:0]             seed_in,
`ifdef PIECE_PURE_RAND_EN
    input  logic                          pure_rand,
`endif
    output logic                          piece_valid,
    output logic [ID_W-1:0]               piece_id,
    output logic [PREVIEW_DEPTH*ID_W-1:0] preview_ids,
    output logic [$clog2(PREVIEW_DEPTH+2)-1:0] queue_count
);

    localparam int DEPTH = PREVIEW_DEPTH + 1;
    localparam int CNT_W = $clog2(PREVIEW_DEPTH + 2);
    localparam int TRY_W = $clog2(MAX_TRIES + 2);

    logic [LFSR_W-1:0]     lfsr_q;
    logic                  lfsr_unused;
    logic                  rand_mode;
    state_t                state, state_next;
    logic [TRY_W-1:0]      tries, tries_next;
    logic [ID_W-1:0]       cand, cand_next;
    logic [ID_W-1:0]       draw_id;
    logic                  draw_ok;
    logic [NUM_PIECES-1:0] mask, mask_next, mask_eff, mask_cleared, cand_onehot;
    logic [ID_W-1:0]       fifo      [DEPTH];
    logic [ID_W-1:0]       fifo_next [DEPTH];
    logic [CNT_W-1:0]      count, count_next, tail;
    logic                  valid_q;
    logic                  pop, push;

    lfsr_core #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (seed_load),
        .load_val (seed_in),
        .q        (lfsr_q)
    );

`ifdef PIECE_PURE_RAND_EN
    assign rand_mode = pure_rand;
`else
    assign rand_mode = 1'b0;
`endif

    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_PIECES-1:0] m);
        lowest_set = '0;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = ID_W'(i);
        end
    endfunction

    assign lfsr_unused  = ^lfsr_q[LFSR_W-1:ID_W];
    assign draw_id      = lfsr_q[ID_W-1:0];
    assign mask_eff     = rand_mode ? '1 : mask;
    assign mask_cleared = mask & ~cand_onehot;
    assign pop          = block_new && (count != '0);
    assign push         = (state == S_PUSH);

    always_comb begin
        draw_ok     = 1'b0;
        cand_onehot = '0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            if (draw_id == ID_W'(i) && mask_eff[i]) draw_ok = 1'b1;
            cand_onehot[i] = (cand == ID_W'(i));
        end
    end

    // Pop shifts the head out; push lands behind whatever survives the pop.
    always_comb begin
        fifo_next  = fifo;
        count_next = count;
        tail       = count;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) fifo_next[i] = fifo[i+1];
            fifo_next[DEPTH-1] = '0;
            count_next = count - CNT_W'(1);
            tail       = count - CNT_W'(1);
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tail == CNT_W'(i)) fifo_next[i] = cand;
            end
            count_next = count_next + CNT_W'(1);
        end
    end

    // The fallback check comes before acceptance so MAX_TRIES=0 deals in fixed order.
    always_comb begin
        state_next = state;
        tries_next = tries;
        cand_next  = cand;
        mask_next  = mask;
        case (state)
            S_IDLE: begin
                if (count < CNT_W'(DEPTH)) state_next = S_DRAW;
            end
            S_DRAW: begin
                if (tries == TRY_W'(MAX_TRIES)) begin
                    cand_next  = lowest_set(mask_eff);
                    state_next = S_PUSH;
                end else if (draw_ok) begin
                    cand_next  = draw_id;
                    state_next = S_PUSH;
                end else begin
                    tries_next = tries + TRY_W'(1);
                end
            end
            S_PUSH: begin
                tries_next = '0;
                if (!rand_mode) mask_next = (mask_cleared == '0) ? '1 : mask_cleared;
                state_next = (count_next == CNT_W'(DEPTH)) ? S_IDLE : S_DRAW;
            end
            default: state_next = S_DRAW;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_DRAW;
            tries   <= '0;
            cand    <= '0;
            mask    <= '1;
            count   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else if (seed_load) begin
            state   <= S_DRAW;
            tries   <= '0;
            cand    <= '0;
            mask    <= '1;
            count   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            state   <= state_next;
            tries   <= tries_next;
            cand    <= cand_next;
            mask    <= mask_next;
            count   <= count_next;
            valid_q <= (count_next != '0);
            for (int i = 0; i < DEPTH; i++) fifo[i] <= fifo_next[i];
        end
    end

    always_comb begin
        preview_ids = '0;
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            preview_ids[i*ID_W +: ID_W] = fifo[i+1];
        end
    end

    assign piece_valid = valid_q;
    assign piece_id    = fifo[0];
    assign queue_count = count;

endmodule
